// File: rtl/timer_pkg.sv
// Shared constants for the programmable timer: write-bus register map, CTRL bit
// positions and counting modes.
package timer_pkg;

    typedef enum logic [1:0] {
        A_CTRL   = 2'd0,
        A_RELOAD = 2'd1,
        A_COUNT  = 2'd2,
        A_IRQCLR = 2'd3
    } wr_addr_e;

    localparam int unsigned EN      = 0;
    localparam int unsigned MODE    = 1;
    localparam int unsigned RESTART = 2;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick enable every PRESC_MAX+1
// clk cycles; tick is decoded combinationally from the counter.
module tick_prescaler #(
    parameter int unsigned PRESC_MAX = 25000,
    parameter int unsigned PRESC_W   = 15
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == PRESC_W'(PRESC_MAX));
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer: one shared prescaler tick drives NCH
// independent up-counters with compare/reload, periodic/one-shot mode and sticky irq.
module prog_timer
    import timer_pkg::*;
#(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned NCH       = 2,
    parameter  int unsigned PRESC_MAX = 25000,
    parameter  int unsigned PRESC_W   = 15,
    localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [1:0]           wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [NCH*WIDTH-1:0] count_out,
    output logic [NCH*3-1:0]     ctrl_out,
    output logic [NCH-1:0]       irq,
    output logic                 tick
);

    logic w_tick;

    tick_prescaler #(
        .PRESC_MAX (PRESC_MAX),
        .PRESC_W   (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign tick = w_tick;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_reload;
        logic             r_en;
        logic             r_mode;
        logic             r_irq;
        logic             w_sel;
        logic             w_cnt_wr;
        logic             w_restart;
        logic             w_match;

        // Out-of-range channel numbers never equal any g, so they select nothing.
        assign w_sel     = wr_en && (wr_ch == CH_W'(g));
        assign w_cnt_wr  = w_sel && (wr_addr == A_COUNT);
        assign w_restart = w_sel && (wr_addr == A_CTRL) && wr_data[RESTART];
        assign w_match   = w_tick && r_en && (r_count == r_reload)
                           && !w_cnt_wr && !w_restart;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_count  <= '0;
                r_reload <= '0;
                r_en     <= 1'b0;
                r_mode   <= MODE_PERIODIC;
                r_irq    <= 1'b0;
            end else begin
                if (w_cnt_wr) begin
                    r_count <= wr_data;
                end else if (w_restart) begin
                    r_count <= '0;
                end else if (w_match) begin
                    if (r_mode == MODE_PERIODIC) begin
                        r_count <= '0;
                    end else begin
                        r_en <= 1'b0;
                    end
                end else if (w_tick && r_en) begin
                    r_count <= r_count + 1'b1;
                end

                if (w_match) begin
                    r_irq <= 1'b1;
                end else if (w_sel && (wr_addr == A_IRQCLR)) begin
                    r_irq <= 1'b0;
                end

                if (w_sel && (wr_addr == A_RELOAD)) begin
                    r_reload <= wr_data;
                end

                // Placed last so a CTRL write overrides a one-shot auto-disable.
                if (w_sel && (wr_addr == A_CTRL)) begin
                    r_en   <= wr_data[EN];
                    r_mode <= wr_data[MODE];
                end
            end
        end

        assign count_out[g*WIDTH +: WIDTH] = r_count;
        assign ctrl_out[g*3 +: 3]          = {1'b0, r_mode, r_en};
        assign irq[g]                      = r_irq;
    end

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench: two timers (prescaler periods 5 and 1) share one write bus
// and are compared every cycle against a behavioural model, plus directed checks.
module tb_prog_timer;

    localparam int NCH = 3;
    localparam int W   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;

    logic [NCH*W-1:0] cnt_a, cnt_b;
    logic [NCH*3-1:0] ctl_a, ctl_b;
    logic [NCH-1:0]   irq_a, irq_b;
    logic             tick_a, tick_b;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt  [2][NCH];
    int m_rel  [2][NCH];
    bit m_en   [2][NCH];
    bit m_mode [2][NCH];
    bit m_irq  [2][NCH];
    int m_cyc;
    int pmax   [2] = '{4, 0};

    always #5 clk = ~clk;

    prog_timer #(.WIDTH(W), .NCH(NCH), .PRESC_MAX(4), .PRESC_W(3)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .count_out(cnt_a), .ctrl_out(ctl_a), .irq(irq_a), .tick(tick_a)
    );

    prog_timer #(.WIDTH(W), .NCH(NCH), .PRESC_MAX(0), .PRESC_W(1)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .count_out(cnt_b), .ctrl_out(ctl_b), .irq(irq_b), .tick(tick_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_tick(input int d);
        return (m_cyc % (pmax[d] + 1)) == pmax[d];
    endfunction

    task automatic model_step();
        bit t [2];
        bit sel, cwr, rs, hit;
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[d][c] = 0; m_rel[d][c] = 0;
                    m_en[d][c] = 0; m_mode[d][c] = 0; m_irq[d][c] = 0;
                end
            m_cyc = 0;
            return;
        end
        for (int d = 0; d < 2; d++) t[d] = model_tick(d);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                sel = wr_en && (int'(wr_ch) == c);
                cwr = sel && wr_addr == 2'd2;
                rs  = sel && wr_addr == 2'd0 && wr_data[2];
                hit = t[d] && m_en[d][c] && m_cnt[d][c] == m_rel[d][c] && !cwr && !rs;
                if (cwr)                    m_cnt[d][c] = int'(wr_data);
                else if (rs)                m_cnt[d][c] = 0;
                else if (hit) begin
                    if (m_mode[d][c])       m_en[d][c] = 0;
                    else                    m_cnt[d][c] = 0;
                end
                else if (t[d] && m_en[d][c]) m_cnt[d][c] = (m_cnt[d][c] + 1) % 65536;
                if (hit)                    m_irq[d][c] = 1;
                else if (sel && wr_addr == 2'd3) m_irq[d][c] = 0;
                if (sel && wr_addr == 2'd1) m_rel[d][c] = int'(wr_data);
                if (sel && wr_addr == 2'd0) begin
                    m_en[d][c]   = wr_data[0];
                    m_mode[d][c] = wr_data[1];
                end
            end
        m_cyc++;
    endtask

    task automatic check_model(input bit do_tick);
        logic [15:0] gc;
        logic [2:0]  gt;
        logic        gi;
        for (int d = 0; d < 2; d++) begin
            if (do_tick)
                check_eq($sformatf("tick%0d", d), d ? tick_b : tick_a, model_tick(d));
            else
                for (int c = 0; c < NCH; c++) begin
                    gc = d ? cnt_b[c*W +: W] : cnt_a[c*W +: W];
                    gt = d ? ctl_b[c*3 +: 3] : ctl_a[c*3 +: 3];
                    gi = d ? irq_b[c] : irq_a[c];
                    check_eq($sformatf("count%0d_%0d", d, c), gc, m_cnt[d][c]);
                    check_eq($sformatf("ctrl%0d_%0d", d, c), gt, {1'b0, m_mode[d][c], m_en[d][c]});
                    check_eq($sformatf("irq%0d_%0d", d, c), gi, m_irq[d][c]);
                end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst) check_model(1'b1);
        @(posedge clk);
        model_step();
        #1;
        check_model(1'b0);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_ch = ch; wr_addr = addr; wr_data = data;
        cycle();
        wr_en = 1'b0;
    endtask

    int seq [5] = '{1, 2, 3, 0, 1};
    int k;
    bit found;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        @(posedge clk); model_step(); #1;
        cycle();
        rst = 1'b0;
        check_eq("reset_count_a", cnt_a, 0);
        check_eq("reset_irq_b", irq_b, 0);

        // periodic, reload 3, tick every cycle on DUT b
        wr(2'd0, 2'd1, 16'd3);
        wr(2'd0, 2'd0, 16'h0005);
        check_eq("per_start", cnt_b[15:0], 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) check_eq("per_irq_pre", irq_b[0], 1'b0);
            cycle();
            check_eq($sformatf("per_seq%0d", i), cnt_b[15:0], seq[i]);
        end
        check_eq("per_irq", irq_b[0], 1'b1);

        // one-shot on channel 1, reload 2
        wr(2'd1, 2'd1, 16'd2);
        wr(2'd1, 2'd0, 16'h0007);
        repeat (6) cycle();
        check_eq("os_hold", cnt_b[31:16], 16'd2);
        check_eq("os_ctrl", ctl_b[5:3], 3'b010);
        check_eq("os_irq", irq_b[1], 1'b1);

        // IRQ_CLR colliding with a match keeps irq set
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_cnt[1][0] == 3) found = 1;
            else cycle();
        end
        check_eq("wait_match", found, 1'b1);
        wr(2'd0, 2'd3, 16'd0);
        check_eq("clr_collide", irq_b[0], 1'b1);
        wr(2'd0, 2'd3, 16'd0);
        check_eq("clr_later", irq_b[0], 1'b0);
        wr(2'd0, 2'd2, 16'h00FF);
        check_eq("cnt_wr_tick", cnt_b[15:0], 16'h00FF);

        // wrap past reload without an early match
        wr(2'd0, 2'd1, 16'd2);
        wr(2'd0, 2'd2, 16'hFFFF);
        check_eq("wrap_pre", cnt_b[15:0], 16'hFFFF);
        wr(2'd0, 2'd3, 16'd0);
        check_eq("wrap_cnt", cnt_b[15:0], 16'h0000);
        check_eq("wrap_irq", irq_b[0], 1'b0);

        // out-of-range channel writes are ignored
        for (int a = 0; a < 4; a++) wr(2'd3, a[1:0], 16'h1235);
        check_eq("oor_cnt1", cnt_b[31:16], 16'd2);
        check_eq("oor_irq1", irq_b[1], 1'b1);
        check_eq("oor_cnt2", cnt_b[47:32], 16'd0);
        check_eq("oor_ctl2", ctl_b[8:6], 3'b000);

        // reset mid-run
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("mrst_cnt_b", cnt_b, 0);
        check_eq("mrst_irq_b", irq_b, 0);
        check_eq("mrst_ctl_b", ctl_b, 0);
        check_eq("mrst_tick_a", tick_a, 1'b0);
        repeat (3) cycle();
        check_eq("presc_early", tick_a, 1'b0);
        cycle();
        check_eq("presc_tick", tick_a, 1'b1);
        cycle();
        check_eq("presc_wrap", tick_a, 1'b0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_addr = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            if (k < 6)      wr_data = 16'($urandom_range(0, 7));
            else if (k < 8) wr_data = 16'hFFFF - 16'($urandom_range(0, 3));
            else            wr_data = 16'($urandom);
            cycle();
        end
        rst = 1'b0; wr_en = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
